// File: rtl/complete_table_if.sv
// complete_table_if -- handshake bundle for the completion table.
//   master : dispatch/completion/commit-consumer side (drives requests)
//   slave  : the table itself
// Signals: flash, alloc_en/alloc_tag/alloc_full, complete_en/complete_msg/
//          complete_reject, commit_stall/commit_en/commit_data, err.
interface complete_table_if #(parameter int TAG_W = 5);
  logic             flash;
  logic             alloc_en;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_full;
  logic             complete_en;
  logic [56:0]      complete_msg;
  logic             complete_reject;
  logic             commit_stall;
  logic             commit_en;
  logic [56:0]      commit_data;
  logic             err;

  modport master (
    output flash, alloc_en, complete_en, complete_msg, commit_stall,
    input  alloc_tag, alloc_full, complete_reject, commit_en, commit_data, err
  );

  modport slave (
    input  flash, alloc_en, complete_en, complete_msg, commit_stall,
    output alloc_tag, alloc_full, complete_reject, commit_en, commit_data, err
  );
endinterface

// File: rtl/complete_table.sv
// complete_table -- in-order retirement table for out-of-order completions.
// Entries are allocated at tail, completed in any order by tag, and retired
// in order from head through a two-stage commit pipeline (S0: done check and
// RAM read, S1: registered commit_en/commit_data).
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   bus (slave)         : flash, alloc_*, complete_*, commit_*, err
// Optional feature: define COMPLETE_TABLE_CHECK_EN to reject completions
// whose tag lies outside [head, tail) and raise a sticky err.
module complete_table #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  complete_table_if.slave   bus
);
  localparam int MSG_W = 57;
  localparam int PAY_W = 52;

  logic [TAG_W:0]     head, tail;
  logic [DEPTH-1:0]   done, done_nxt;
  logic [PAY_W-1:0]   ram [DEPTH];
  logic               commit_en_q;
  logic [MSG_W-1:0]   commit_data_q, cmsg;

  logic [TAG_W-1:0]   head_idx, tail_idx, c_tag;
  logic [PAY_W-1:0]   c_pay;
  logic               full, range_bad, xfer, do_alloc, do_commit, s1_hold;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign c_tag    = bus.complete_msg[PAY_W +: TAG_W];
  assign c_pay    = bus.complete_msg[PAY_W-1:0];

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign full = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);

`ifdef COMPLETE_TABLE_CHECK_EN
  logic [TAG_W-1:0] off;
  logic [TAG_W:0]   cnt;
  logic             err_q;
  // Tag is in flight iff its distance from head is below the occupancy.
  assign off       = c_tag - head_idx;
  assign cnt       = tail - head;
  assign range_bad = ({1'b0, off} >= cnt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            err_q <= 1'b0;
    else if (bus.complete_en && range_bad)   err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign range_bad = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.complete_reject = bus.flash | (bus.complete_en & range_bad);
  assign xfer      = bus.complete_en & ~bus.complete_reject;
  assign do_alloc  = bus.alloc_en & ~full & ~bus.flash;
  // S1 holds only while it actually carries a commit the consumer refuses.
  assign s1_hold   = commit_en_q & bus.commit_stall;
  assign do_commit = done[head_idx] & ~s1_hold & ~bus.flash;

  assign bus.alloc_tag   = tail_idx;
  assign bus.alloc_full  = full;
  assign bus.commit_en   = commit_en_q;
  assign bus.commit_data = commit_data_q;

  // Order matters on index collisions: a retiring head always clears.
  always_comb begin
    done_nxt = done;
    if (do_alloc)  done_nxt[tail_idx] = 1'b0;
    if (xfer)      done_nxt[c_tag]    = 1'b1;
    if (do_commit) done_nxt[head_idx] = 1'b0;
  end

  always_comb begin
    cmsg                   = '0;
    cmsg[PAY_W-1:0]        = ram[head_idx];
    cmsg[PAY_W +: TAG_W]   = head_idx;
  end

  // Payload storage: synchronous write, no reset.
  always_ff @(posedge clock) begin
    if (xfer) ram[c_tag] <= c_pay;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head          <= '0;
      tail          <= '0;
      done          <= '0;
      commit_en_q   <= 1'b0;
      commit_data_q <= '0;
    end else if (bus.flash) begin
      head        <= '0;
      tail        <= '0;
      done        <= '0;
      commit_en_q <= 1'b0;
    end else begin
      done <= done_nxt;
      if (do_alloc) tail <= tail + 1'b1;
      if (do_commit) begin
        head          <= head + 1'b1;
        commit_en_q   <= 1'b1;
        commit_data_q <= cmsg;
      end else if (!s1_hold) begin
        commit_en_q   <= 1'b0;
      end
    end
  end
endmodule
